// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg -- shared mode type, default sizing and duty-bus slice helper. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_PERIOD_RST = 999;

  // LSB of channel ch inside the packed duty bus.
  function automatic int duty_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel -- one PWM lane: active duty, comparator, registered output. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             apply_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] duty_q, duty_d, duty_eff;
  logic             pwm_q, pwm_d;

  // On an applying boundary the new duty already governs the count-0 compare,
  // so the whole new cycle uses one duty value.
  always_comb begin
    duty_eff = apply_i ? duty_i : duty_q;
    duty_d   = duty_eff;
    pwm_d    = (count_i < duty_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

`default_nettype wire

// File: rtl/pwm_bank.sv
// ---------------------------------------------------------------------------
// pwm_bank -- NUM_CH PWM channels sharing one counter with boundary-shadowed
// period/duty/mode. Center-aligned mode built only with PWM_BANK_CENTER_EN. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_bank
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PERIOD_RST = DEF_PERIOD_RST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        period,
  input  logic [NUM_CH*WIDTH-1:0] duty,
  input  logic                    load,
  input  logic                    center_mode,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    cycle_start,
  output logic                    update_ack
);

  localparam logic [WIDTH-1:0] PERIOD_RST_W = WIDTH'(PERIOD_RST);

  logic [WIDTH-1:0]        count_q, count_d;
  logic [WIDTH-1:0]        act_period_q, act_period_d;
  logic [WIDTH-1:0]        pend_period_q, pend_period_d;
  logic [WIDTH-1:0]        eff_period;
  logic [NUM_CH*WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic                    pend_q, pend_d;
  logic                    boundary, apply;

`ifdef PWM_BANK_CENTER_EN
  pwm_mode_e act_mode_q, act_mode_d;
  pwm_mode_e pend_mode_q, pend_mode_d;
  pwm_mode_e eff_mode;
  logic      dir_up_q, dir_up_d;
`else
  logic      unused_center_mode;
  assign unused_center_mode = center_mode;
`endif

  assign boundary   = (count_q == '0);
  assign apply      = boundary && pend_q;
  assign eff_period = apply ? pend_period_q : act_period_q;

  // A coincident load lands in the shadow after the old shadow has been consumed.
  always_comb begin : shadow
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pend_d        = pend_q;
    act_period_d  = eff_period;
    if (apply) begin
      pend_d = 1'b0;
    end
    if (load) begin
      pend_period_d = period;
      pend_duty_d   = duty;
      pend_d        = 1'b1;
    end
  end

`ifdef PWM_BANK_CENTER_EN
  assign eff_mode = apply ? pend_mode_q : act_mode_q;

  always_comb begin : mode_shadow
    act_mode_d  = eff_mode;
    pend_mode_d = pend_mode_q;
    if (load) begin
      pend_mode_d = center_mode ? MODE_CENTER : MODE_EDGE;
    end
  end
`endif

  always_comb begin : counter
    count_d = count_q;
`ifdef PWM_BANK_CENTER_EN
    dir_up_d = dir_up_q;
`endif
    if (boundary) begin
      count_d = (eff_period == '0) ? '0 : WIDTH'(1);
`ifdef PWM_BANK_CENTER_EN
      dir_up_d = 1'b1;
`endif
    end
`ifdef PWM_BANK_CENTER_EN
    else if (eff_mode == MODE_CENTER) begin
      // Turn around at P going up; heading back to 0 from count 1 re-arms up.
      if (dir_up_q && (count_q < eff_period)) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d  = count_q - WIDTH'(1);
        dir_up_d = (count_q == WIDTH'(1));
      end
    end
`endif
    else if (count_q >= eff_period) begin
      count_d = '0;
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      act_period_q  <= PERIOD_RST_W;
      pend_period_q <= PERIOD_RST_W;
      pend_duty_q   <= '0;
      pend_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      act_period_q  <= act_period_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_q        <= pend_d;
    end
  end

`ifdef PWM_BANK_CENTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_mode_q  <= MODE_EDGE;
      pend_mode_q <= MODE_EDGE;
      dir_up_q    <= 1'b1;
    end else begin
      act_mode_q  <= act_mode_d;
      pend_mode_q <= pend_mode_d;
      dir_up_q    <= dir_up_d;
    end
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .apply_i(apply),
      .duty_i (pend_duty_q[duty_lsb(i, WIDTH) +: WIDTH]),
      .count_i(count_q),
      .pwm_o  (pwm_out[i])
    );
  end

  // Gated by rst_n so both strobes read 0 throughout reset.
  assign cycle_start = rst_n & boundary;
  assign update_ack  = rst_n & apply;

endmodule

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_bank -- scoreboard bench for pwm_bank against a cycle-position model. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_bank;

  localparam int NCH  = 3;
  localparam int W    = 10;
  localparam int PRST = 999;
`ifdef PWM_BANK_CENTER_EN
  localparam bit CENTER_BUILT = 1'b1;
`else
  localparam bit CENTER_BUILT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     period;
  logic [NCH*W-1:0] duty;
  logic             load;
  logic             center_mode;
  logic [NCH-1:0]   pwm_out;
  logic             cycle_start;
  logic             update_ack;

  pwm_bank #(.NUM_CH(NCH), .WIDTH(W), .PERIOD_RST(PRST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .period     (period),
    .duty       (duty),
    .load       (load),
    .center_mode(center_mode),
    .pwm_out    (pwm_out),
    .cycle_start(cycle_start),
    .update_ack (update_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the current PWM cycle plus active/pending sets.
  int aP, pP, pos;
  int aD[NCH];
  int pD[NCH];
  bit aM, pM, pend;
  bit [NCH-1:0] prev_out;
  int cur_p, cur_d0, cur_d1, cur_d2;
  bit cur_cm;

  logic [4:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  function automatic int cyc_len(input int p, input bit m);
    if (m) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  task automatic model_reset();
    aP = PRST; pP = PRST; pos = 0;
    aM = 1'b0; pM = 1'b0; pend = 1'b0; prev_out = '0;
    for (int i = 0; i < NCH; i++) begin aD[i] = 0; pD[i] = 0; end
  endtask

  task automatic step(input bit r, input bit ld, input int p, input int d0,
                      input int d1, input int d2, input bit cm);
    logic [4:0] e;
    int c;
    bit ack;
    @(posedge clk); #1;
    rst_n = r; load = ld; period = p[W-1:0];
    duty = {d2[W-1:0], d1[W-1:0], d0[W-1:0]}; center_mode = cm;
    if (!r) begin
      model_reset();
      e = '0;
    end else begin
      ack = 1'b0;
      if (pos == 0 && pend) begin
        aP = pP; aM = pM; pend = 1'b0; ack = 1'b1;
        for (int i = 0; i < NCH; i++) aD[i] = pD[i];
      end
      e = {prev_out, (pos == 0), ack};
      c = (aM && pos > aP) ? 2 * aP - pos : pos;
      for (int i = 0; i < NCH; i++) prev_out[i] = (c < aD[i]);
      if (ld) begin
        pP = p; pD[0] = d0; pD[1] = d1; pD[2] = d2;
        pM = CENTER_BUILT && cm; pend = 1'b1;
      end
      pos = (pos + 1) % cyc_len(aP, aM);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, cur_p, cur_d0, cur_d1, cur_d2, cur_cm);
  endtask

  task automatic do_load(input int p, input int d0, input int d1, input int d2, input bit cm);
    cur_p = p; cur_d0 = d0; cur_d1 = d1; cur_d2 = d2; cur_cm = cm;
    step(1'b1, 1'b1, p, d0, d1, d2, cm);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, cur_p, cur_d0, cur_d1, cur_d2, cur_cm);
  endtask

  task automatic idle_to_pos(input int k);
    int guard;
    guard = 0;
    while (pos != k && guard < 2100) begin idle(1); guard++; end
    if (pos != k) begin
      miscompares++;
      $display("FAIL pos_wait: reached %0d, required %0d", pos, k);
    end
  endtask

  // Monitor: one expected vector per clock, compared mid-cycle.
  initial begin
    logic [4:0] e, got;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pwm_out, cycle_start, update_ack};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL cyc%0d {pwm_out,cycle_start,update_ack}: got %b required %b", cyc, got, e);
        end
      end
    end
  end

  initial begin
    int rr;
    rst_n = 1'b0; load = 1'b0; period = '0; duty = '0; center_mode = 1'b0;
    cur_p = PRST; cur_d0 = 0; cur_d1 = 0; cur_d2 = 0; cur_cm = 1'b0;
    model_reset();

    do_reset(3);
    idle(4);

    // Edge mode P=9, duties 0 / 5 / above-period.
    do_load(9, 0, 5, 12, 1'b0);
    idle_to_pos(0);
    idle(32);

    // Duty 3 -> 7 requested mid-cycle at count 4.
    do_load(9, 3, 3, 3, 1'b0);
    idle_to_pos(0);
    idle(12);
    idle_to_pos(4);
    do_load(9, 7, 7, 7, 1'b0);
    idle(24);

    // Load exactly on the boundary cycle, then a back-to-back overwrite.
    idle_to_pos(0);
    do_load(9, 2, 9, 10, 1'b0);
    idle(3);
    do_load(9, 1, 4, 8, 1'b0);
    idle(24);

    // Period shrink 9 -> 3 requested at count 7.
    idle_to_pos(7);
    do_load(3, 1, 2, 4, 1'b0);
    idle(16);

    // Center-aligned P=8 duty 4 (edge-only build must ignore center_mode).
    idle_to_pos(0);
    do_load(8, 4, 4, 4, 1'b1);
    idle_to_pos(0);
    idle(40);
    do_load(0, 1, 0, 1, 1'b1);
    idle(6);
    do_load(1, 1, 2, 0, 1'b1);
    idle(8);

    // Reset mid-cycle with a pending load outstanding.
    do_load(9, 5, 5, 5, 1'b0);
    idle_to_pos(0);
    idle_to_pos(5);
    do_load(4, 2, 2, 2, 1'b0);
    idle(1);
    do_reset(2);
    idle(20);

    // Randomized traffic: occasional loads, rare resets.
    do_load(15, 3, 7, 16, 1'b0);
    for (int k = 0; k < 1800; k++) begin
      rr = int'($urandom_range(0, 299));
      if (rr == 0) begin
        do_reset(1);
      end else if (rr < 15) begin
        do_load(int'($urandom_range(0, 20)), int'($urandom_range(0, 22)),
                int'($urandom_range(0, 22)), int'($urandom_range(0, 22)),
                1'($urandom_range(0, 1)));
      end else begin
        idle(1);
      end
    end

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
